// File: rtl/ms2xs_pkg.sv
// ms2xs_pkg: shared types, field offsets and helpers for the ms2xs feeder.
package ms2xs_pkg;

    localparam logic [1:0] T_ZERO = 2'b00;
    localparam logic [1:0] T_POS  = 2'b01;
    localparam logic [1:0] T_NEG  = 2'b10;

    localparam int H_LSB   = 4;
    localparam int R_LSB   = 2;
    localparam int SEL_LSB = 24;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    // The illegal code 2'b11 is forwarded to the multiplier as zero.
    function automatic logic [1:0] tcode(input logic [1:0] c);
        return (c == T_POS || c == T_NEG) ? c : T_ZERO;
    endfunction

endpackage

// File: rtl/ms2xs_skid.sv
// ms2xs_skid: two-entry FIFO; the head entry drives the output directly.
module ms2xs_skid #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic [1:0]   occ_o
);
    logic [W-1:0] head_q, tail_q;
    logic [1:0]   occ_q, occ_d;
    logic         to_head;

    assign occ_d   = occ_q + {1'b0, push_i} - {1'b0, pop_i};
    assign to_head = occ_q == 2'd0 || (occ_q == 2'd1 && pop_i);
    assign dout_o  = head_q;
    assign occ_o   = occ_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            occ_q <= occ_d;
            if (pop_i) head_q <= tail_q;
            if (push_i && to_head) head_q <= din_i;
            if (push_i && !to_head) tail_q <= din_i;
        end
    end

endmodule

// File: rtl/ms2xs_feeder.sv
// ms2xs_feeder: streams packed (h, r, m) coefficient words to the NTRU multiplier
// and writes the returned result words into the result buffer.
module ms2xs_feeder
    import ms2xs_pkg::*;
#(
    parameter  int D_WIDTH = 32,
    parameter  int N       = 11,
    parameter  int q       = 2048,
    parameter  int SRC_LAT = 1,
    localparam int QW      = clog2(q - 1),
    localparam int AW      = clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         sel,
    output logic [AW-1:0]      src_addr,
    output logic               src_re,
    input  logic [QW-1:0]      src_h,
    input  logic [1:0]         src_r,
    input  logic [1:0]         src_m,
    output logic [D_WIDTH-1:0] m_tdata,
    output logic               m_tvalid,
    output logic               m_tlast,
    input  logic               m_tready,
    input  logic [D_WIDTH-1:0] s_tdata,
    input  logic               s_tvalid,
    input  logic               s_tlast,
    output logic               s_tready,
    output logic               res_we,
    output logic [AW-1:0]      res_addr,
    output logic [QW-1:0]      res_data,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    if (QW + 4 > 24 || SRC_LAT != 1 || D_WIDTH < SEL_LSB + 2) begin : g_bad_cfg
        $error("ms2xs_feeder: unsupported parameter set");
    end

    state_t          state_q;
    logic [1:0]      sel_q, occ;
    logic [AW-1:0]   rd_cnt_q, wr_cnt_q;
    logic            rd_done_q, tx_done_q, rx_done_q, inflight_q, inflight_last_q;
    logic            m_hs, s_hs, rx_last, tx_fin, rx_fin;
    logic [D_WIDTH:0] head, push_word;
    logic [D_WIDTH-QW-3:0] unused_hi;

    assign m_hs      = m_tvalid && m_tready;
    assign s_hs      = s_tvalid && s_tready;
    assign m_tvalid  = occ != 2'd0;
    assign m_tdata   = head[D_WIDTH-1:0];
    assign m_tlast   = m_tvalid && head[D_WIDTH];
    assign s_tready  = state_q == S_RUN && !rx_done_q;
    assign res_we    = s_hs;
    assign res_addr  = wr_cnt_q;
    assign res_data  = s_tdata[QW-1:0];
    assign src_addr  = rd_cnt_q;
    assign rx_last   = s_tlast || wr_cnt_q == LAST;
    assign tx_fin    = tx_done_q || (m_hs && m_tlast);
    assign rx_fin    = rx_done_q || (s_hs && rx_last);
    assign unused_hi = s_tdata[D_WIDTH-1:QW+2];

    // Occupancy is taken net of this cycle's pop so a full-rate stream never bubbles.
    assign src_re = reset && !rd_done_q &&
        (state_q == S_IDLE ? start :
         state_q == S_RUN && (3'(occ) + 3'(inflight_q) - 3'(m_hs)) < 3'd2);

    always_comb begin
        push_word                  = '0;
        push_word[D_WIDTH]         = inflight_last_q;
        push_word[H_LSB +: QW]     = src_h;
        push_word[R_LSB +: 2]      = tcode(src_r);
        push_word[1:0]             = tcode(src_m);
        push_word[SEL_LSB +: 2]    = sel_q;
    end

    ms2xs_skid #(.W(D_WIDTH + 1)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .push_i (inflight_q),
        .pop_i  (m_hs),
        .din_i  (push_word),
        .dout_o (head),
        .occ_o  (occ)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            sel_q           <= '0;
            rd_cnt_q        <= '0;
            wr_cnt_q        <= '0;
            rd_done_q       <= 1'b0;
            tx_done_q       <= 1'b0;
            rx_done_q       <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else begin
            inflight_q      <= src_re;
            inflight_last_q <= rd_cnt_q == LAST;
            if (src_re) begin
                if (rd_cnt_q == LAST) rd_done_q <= 1'b1;
                else rd_cnt_q <= rd_cnt_q + AW'(1);
            end
            if (m_hs && m_tlast) tx_done_q <= 1'b1;
            if (s_hs) begin
                if (rx_last) rx_done_q <= 1'b1;
                else wr_cnt_q <= wr_cnt_q + AW'(1);
                if (s_tdata[QW +: 2] != sel_q || s_tlast != (wr_cnt_q == LAST)) err <= 1'b1;
            end
            case (state_q)
                S_IDLE: if (start) begin
                    state_q <= S_RUN;
                    busy    <= 1'b1;
                    sel_q   <= sel;
                    err     <= 1'b0;
                end
                S_RUN: if (tx_fin && rx_fin) begin
                    state_q <= S_FIN;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
                default: begin
                    state_q   <= S_IDLE;
                    done      <= 1'b0;
                    rd_cnt_q  <= '0;
                    wr_cnt_q  <= '0;
                    rd_done_q <= 1'b0;
                    tx_done_q <= 1'b0;
                    rx_done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ms2xs_feeder.sv
// tb_ms2xs_feeder: directed bench for ms2xs_feeder with an in-bench coefficient store.
module tb_ms2xs_feeder;
    localparam int N = 11;

    logic        clk = 1'b0;
    logic        reset, start, m_tready, s_tvalid, s_tlast;
    logic [1:0]  sel;
    logic [3:0]  src_addr, res_addr;
    logic        src_re, m_tvalid, m_tlast, s_tready, res_we, busy, done, err;
    logic [10:0] src_h = '0, res_data;
    logic [1:0]  src_r = '0, src_m = '0;
    logic [31:0] m_tdata, s_tdata;

    int          vecs = 0, miss = 0;
    int          nsent, nwr, dcnt, k, first_v, last_v;
    logic [31:0] w0, held;
    bit          stalled;
    logic [15:0] bp_pat = 16'b1001_0110_0011_1001;

    ms2xs_feeder #(.D_WIDTH(32), .N(N), .q(2048), .SRC_LAT(1)) dut (
        .clk(clk), .reset(reset), .start(start), .sel(sel),
        .src_addr(src_addr), .src_re(src_re), .src_h(src_h), .src_r(src_r), .src_m(src_m),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Coefficient store: h = 100k+5, r code = (k+1)%3, m code = (k+2)%3, one-cycle read.
    always @(posedge clk)
        if (src_re) begin
            src_h <= 11'(int'(src_addr) * 100 + 5);
            src_r <= 2'((int'(src_addr) + 1) % 3);
            src_m <= 2'((int'(src_addr) + 2) % 3);
        end

    function automatic logic [31:0] exp_word(input int idx, input logic [1:0] s);
        return (32'(s) << 24) | (32'(idx * 100 + 5) << 4) | (32'((idx + 1) % 3) << 2) | 32'((idx + 2) % 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [1:0] s, input int last_idx, input int bad_idx,
                        input bit bp, input int abort_at, input int restart_at);
        nsent = 0; nwr = 0; dcnt = 0; k = 0; first_v = -1; last_v = -1; stalled = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            start    = (cyc == 0) || (cyc == restart_at);
            sel      = (cyc == restart_at) ? 2'd1 : s;
            m_tready = bp ? bp_pat[cyc % 16] : 1'b1;
            s_tvalid = cyc > 0 && k <= last_idx;
            s_tdata  = ((k == bad_idx ? 32'd1 : 32'(s)) << 11) | 32'(k);
            s_tlast  = k == last_idx;
            #1;
            if (cyc == 1) begin
                chk("busy_on", 32'(busy), 32'd1);
                chk("err_clr", 32'(err), 32'd0);
            end
            if (stalled) begin
                chk("stall_data", m_tdata, held);
                chk("stall_valid", 32'(m_tvalid), 32'd1);
            end
            stalled = m_tvalid && !m_tready;
            held    = m_tdata;
            if (m_tvalid && m_tready) begin
                if (first_v < 0) begin first_v = cyc; w0 = m_tdata; end
                last_v = cyc;
                chk("m_tdata", m_tdata, exp_word(nsent, s));
                chk("m_tlast", 32'(m_tlast), 32'(nsent == N - 1));
                nsent++;
            end
            if (s_tvalid && s_tready) begin
                chk("res_we", 32'(res_we), 32'd1);
                chk("res_addr", 32'(res_addr), 32'(k));
                chk("res_data", 32'(res_data), 32'(k));
                k++;
                nwr++;
            end
            if (done) dcnt++;
            if (done || (abort_at > 0 && nsent == abort_at)) break;
        end
        start = 1'b0;
        s_tvalid = 1'b0;
    endtask

    task automatic finish_checks(input int words, input int writes, input int e);
        chk("words", 32'(nsent), 32'(words));
        chk("writes", 32'(nwr), 32'(writes));
        chk("err_end", 32'(err), 32'(e));
        chk("done_pulses", 32'(dcnt), 32'd1);
        @(negedge clk); #1;
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_after", 32'(done), 32'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; sel = '0; m_tready = 1'b1;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mvalid", 32'(m_tvalid), 32'd0);
        chk("rst_mdata", m_tdata, 32'd0);
        chk("rst_sready", 32'(s_tready), 32'd0);
        chk("rst_srcre", 32'(src_re), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1'b1;

        // Abort after 4 words
        xfer(2'd2, 10, -1, 1'b0, 4, -1);
        chk("abort_words", 32'(nsent), 32'd4);
        chk("abort_done", 32'(dcnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("ab_mvalid", 32'(m_tvalid), 32'd0);
        chk("ab_mlast", 32'(m_tlast), 32'd0);
        chk("ab_mdata", m_tdata, 32'd0);
        chk("ab_sready", 32'(s_tready), 32'd0);
        chk("ab_reswe", 32'(res_we), 32'd0);
        chk("ab_srcre", 32'(src_re), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_err", 32'(err), 32'd0);
        reset = 1'b1;
        dcnt = 0;
        repeat (4) begin @(negedge clk); #1; if (done) dcnt++; end
        chk("ab_nodone", 32'(dcnt), 32'd0);

        // Clean full-rate transfer: packing, latency, throughput, result path
        xfer(2'd2, 10, -1, 1'b0, 0, -1);
        chk("word0", w0, 32'h0200_0056);
        chk("first_valid", 32'(first_v), 32'd2);
        chk("burst_len", 32'(last_v - first_v), 32'd10);
        finish_checks(11, 11, 0);

        // Backpressure
        xfer(2'd3, 10, -1, 1'b1, 0, -1);
        finish_checks(11, 11, 0);

        // Early tlast on result word 6
        xfer(2'd1, 6, -1, 1'b0, 0, -1);
        finish_checks(11, 7, 1);

        // Tag mismatch on word 3, start while busy ignored
        xfer(2'd2, 10, 3, 1'b0, 0, 5);
        finish_checks(11, 11, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
